// File: rtl/req_ack_tracker.sv
// Multi-channel req/ack responder: each accepted req pulse returns an ack exactly
// LATENCY cycles later; reqs inside the per-channel spacing window are rejected and flagged.
module req_ack_tracker #(
  parameter int CHANNELS = 2,
  parameter int LATENCY  = 4,
  parameter int MIN_GAP  = 7,
  parameter int CNT_W    = 8,
  parameter int OUT_W    = $clog2(LATENCY + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       req,
  input  logic [CHANNELS-1:0]       clear_err,
  output logic [CHANNELS-1:0]       ack,
  output logic [CHANNELS-1:0]       err,
  output logic [CHANNELS*OUT_W-1:0] outstanding,
  output logic [CHANNELS*CNT_W-1:0] accepted,
  output logic                      idle
);

  // A zero-width counter is illegal, so MIN_GAP=0 keeps a 1-bit counter that stays at 0.
  localparam int GAP_W = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(MIN_GAP);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [GAP_W-1:0]   gap_cnt;
    logic [LATENCY-1:0] ack_pipe;
    logic [OUT_W-1:0]   out_cnt;
    logic [CNT_W-1:0]   acc_cnt;
    logic               err_q;
    logic               accept;
    logic               reject;
    logic               ack_c;

    assign accept = req[c] && (gap_cnt == '0);
    assign reject = req[c] && (gap_cnt != '0);
    assign ack_c  = ack_pipe[LATENCY-1];

    always_ff @(posedge clk) begin
      if (rst) begin
        gap_cnt  <= '0;
        ack_pipe <= '0;
        out_cnt  <= '0;
        acc_cnt  <= '0;
        err_q    <= 1'b0;
      end else begin
        // Window restarts only on accepted reqs; rejected ones never extend it.
        if (accept) begin
          gap_cnt <= GAP_LOAD;
        end else if (gap_cnt != '0) begin
          gap_cnt <= gap_cnt - GAP_W'(1);
        end

        ack_pipe <= LATENCY'({ack_pipe, accept});

        case ({accept, ack_c})
          2'b10:   out_cnt <= out_cnt + OUT_W'(1);
          2'b01:   out_cnt <= out_cnt - OUT_W'(1);
          default: out_cnt <= out_cnt;
        endcase

        if (accept && (acc_cnt != CNT_MAX)) begin
          acc_cnt <= acc_cnt + CNT_W'(1);
        end

        // A new violation beats a simultaneous clear so no event is lost.
        if (reject) begin
          err_q <= 1'b1;
        end else if (clear_err[c]) begin
          err_q <= 1'b0;
        end
      end
    end

    assign ack[c]                        = ack_c;
    assign err[c]                        = err_q;
    assign outstanding[c*OUT_W +: OUT_W] = out_cnt;
    assign accepted[c*CNT_W +: CNT_W]    = acc_cnt;
  end

  assign idle = (outstanding == '0);

endmodule

// File: tb/tb_req_ack_tracker.sv
// Bench for req_ack_tracker: three instances (defaults, back-to-back, narrow counter)
// checked every cycle against a queue of expected ack times plus directed scenario checks.
module tb_req_ack_tracker;
  localparam int LAT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] req0 = '0, req1 = '0, req2 = '0;
  logic [1:0] clr0 = '0, clr1 = '0, clr2 = '0;
  logic [1:0] ack0, ack1, ack2, err0, err1, err2;
  logic [5:0] out0, out1, out2;
  logic [15:0] acc0, acc1;
  logic [3:0] acc2;
  logic idle0, idle1, idle2;

  int n_assert = 0;
  int n_fail = 0;
  int cyc = 0;

  typedef struct {
    int d;
    int ch;
    int t;
  } ent_t;
  ent_t sb[$];

  int last_acc[3][2];
  int acc_m[3][2];
  bit err_m[3][2];

  always #5 clk = ~clk;

  req_ack_tracker #(.CHANNELS(2), .LATENCY(LAT), .MIN_GAP(7), .CNT_W(8)) dut0 (
    .clk(clk), .rst(rst), .req(req0), .clear_err(clr0), .ack(ack0), .err(err0),
    .outstanding(out0), .accepted(acc0), .idle(idle0));
  req_ack_tracker #(.CHANNELS(2), .LATENCY(LAT), .MIN_GAP(0), .CNT_W(8)) dut1 (
    .clk(clk), .rst(rst), .req(req1), .clear_err(clr1), .ack(ack1), .err(err1),
    .outstanding(out1), .accepted(acc1), .idle(idle1));
  req_ack_tracker #(.CHANNELS(2), .LATENCY(LAT), .MIN_GAP(0), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .req(req2), .clear_err(clr2), .ack(ack2), .err(err2),
    .outstanding(out2), .accepted(acc2), .idle(idle2));

  function automatic int gap_of(int d);
    return (d == 0) ? 7 : 0;
  endfunction

  function automatic int sat_of(int d);
    return (d == 2) ? 3 : 255;
  endfunction

  function automatic logic get_req(int d, int ch);
    case (d)
      0:       return req0[ch];
      1:       return req1[ch];
      default: return req2[ch];
    endcase
  endfunction

  function automatic logic get_clr(int d, int ch);
    case (d)
      0:       return clr0[ch];
      1:       return clr1[ch];
      default: return clr2[ch];
    endcase
  endfunction

  function automatic logic [31:0] get_ack(int d, int ch);
    case (d)
      0:       return 32'(ack0[ch]);
      1:       return 32'(ack1[ch]);
      default: return 32'(ack2[ch]);
    endcase
  endfunction

  function automatic logic [31:0] get_err(int d, int ch);
    case (d)
      0:       return 32'(err0[ch]);
      1:       return 32'(err1[ch]);
      default: return 32'(err2[ch]);
    endcase
  endfunction

  function automatic logic [31:0] get_out(int d, int ch);
    case (d)
      0:       return 32'(out0[ch*3 +: 3]);
      1:       return 32'(out1[ch*3 +: 3]);
      default: return 32'(out2[ch*3 +: 3]);
    endcase
  endfunction

  function automatic logic [31:0] get_acc(int d, int ch);
    case (d)
      0:       return 32'(acc0[ch*8 +: 8]);
      1:       return 32'(acc1[ch*8 +: 8]);
      default: return 32'(acc2[ch*2 +: 2]);
    endcase
  endfunction

  function automatic logic [31:0] get_idle(int d);
    case (d)
      0:       return 32'(idle0);
      1:       return 32'(idle1);
      default: return 32'(idle2);
    endcase
  endfunction

  task automatic chk(string tag, int d, int ch, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s dut%0d ch%0d cycle %0d observed=%0h expected=%0h", tag, d, ch, cyc, obs, exp);
    end
  endtask

  // Predict this cycle's effects, advance one clock, then compare every output.
  task automatic step();
    for (int d = 0; d < 3; d++) begin
      for (int ch = 0; ch < 2; ch++) begin
        if (!rst) begin
          if (get_req(d, ch) && (cyc - last_acc[d][ch] > gap_of(d))) begin
            ent_t e;
            e.d = d;
            e.ch = ch;
            e.t = cyc + LAT;
            sb.push_back(e);
            last_acc[d][ch] = cyc;
            if (acc_m[d][ch] < sat_of(d)) acc_m[d][ch]++;
            if (get_clr(d, ch)) err_m[d][ch] = 1'b0;
          end else if (get_req(d, ch)) begin
            err_m[d][ch] = 1'b1;
          end else if (get_clr(d, ch)) begin
            err_m[d][ch] = 1'b0;
          end
        end
      end
    end
    if (rst) begin
      sb.delete();
      for (int d = 0; d < 3; d++) begin
        for (int ch = 0; ch < 2; ch++) begin
          last_acc[d][ch] = -100;
          acc_m[d][ch] = 0;
          err_m[d][ch] = 1'b0;
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int d = 0; d < 3; d++) begin
      bit busy = 1'b0;
      for (int ch = 0; ch < 2; ch++) begin
        int exp_ack = 0;
        int exp_out = 0;
        for (int i = sb.size() - 1; i >= 0; i--) begin
          if (sb[i].d == d && sb[i].ch == ch) begin
            if (sb[i].t == cyc) exp_ack = 1;
            if (sb[i].t >= cyc) exp_out++;
            if (sb[i].t <= cyc) sb.delete(i);
          end
        end
        if (exp_out != 0) busy = 1'b1;
        chk("ack", d, ch, get_ack(d, ch), exp_ack);
        chk("outstanding", d, ch, get_out(d, ch), exp_out);
        chk("err", d, ch, get_err(d, ch), 32'(err_m[d][ch]));
        chk("accepted", d, ch, get_acc(d, ch), acc_m[d][ch]);
      end
      chk("idle", d, 0, get_idle(d), busy ? 0 : 1);
    end
  endtask

  task automatic run_to(int n);
    while (cyc < n) step();
  endtask

  task automatic do_reset();
    req0 = '0; req1 = '0; req2 = '0;
    clr0 = '0; clr1 = '0; clr2 = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    cyc = 0;
    for (int d = 0; d < 3; d++) begin
      chk("rst_idle", d, 0, get_idle(d), 1);
      for (int ch = 0; ch < 2; ch++) begin
        chk("rst_ack", d, ch, get_ack(d, ch), 0);
        chk("rst_err", d, ch, get_err(d, ch), 0);
        chk("rst_out", d, ch, get_out(d, ch), 0);
        chk("rst_acc", d, ch, get_acc(d, ch), 0);
      end
    end
  endtask

  initial begin
    int pipe_exp[9] = '{1, 2, 3, 4, 4, 3, 2, 1, 0};
    int sat_exp[6] = '{1, 2, 3, 3, 3, 3};

    // Basic latency
    do_reset();
    run_to(10);
    req0[0] = 1'b1; step(); req0[0] = 1'b0;
    chk("lat_out_11", 0, 0, get_out(0, 0), 1);
    run_to(13);
    chk("lat_noack_13", 0, 0, get_ack(0, 0), 0);
    step();
    chk("lat_ack_14", 0, 0, get_ack(0, 0), 1);
    chk("lat_out_14", 0, 0, get_out(0, 0), 1);
    chk("lat_ack1_14", 0, 1, get_ack(0, 1), 0);
    step();
    chk("lat_out_15", 0, 0, get_out(0, 0), 0);
    chk("lat_acc", 0, 0, get_acc(0, 0), 1);

    // Gap violation
    do_reset();
    run_to(10);
    req0[0] = 1'b1; step(); req0[0] = 1'b0;
    run_to(15);
    req0[0] = 1'b1; step(); req0[0] = 1'b0;
    chk("gap_err_16", 0, 0, get_err(0, 0), 1);
    run_to(18);
    req0[0] = 1'b1; step(); req0[0] = 1'b0;
    run_to(19);
    chk("gap_noack_19", 0, 0, get_ack(0, 0), 0);
    run_to(22);
    chk("gap_ack_22", 0, 0, get_ack(0, 0), 1);
    run_to(23);
    chk("gap_acc", 0, 0, get_acc(0, 0), 2);

    // Pipelined back-to-back on the MIN_GAP=0 instance
    do_reset();
    run_to(5);
    req1[1] = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (i == 5) req1[1] = 1'b0;
      step();
      chk("pipe_out", 1, 1, get_out(1, 1), pipe_exp[i]);
      chk("pipe_idle", 1, 1, get_idle(1), (i == 8) ? 1 : 0);
      if (cyc >= 9 && cyc <= 13) chk("pipe_ack", 1, 1, get_ack(1, 1), 1);
    end
    chk("pipe_acc", 1, 1, get_acc(1, 1), 5);

    // Error clear
    do_reset();
    run_to(10);
    req0[0] = 1'b1; step(); req0[0] = 1'b0;
    run_to(12);
    req0[0] = 1'b1; step();
    chk("clr_err_set", 0, 0, get_err(0, 0), 1);
    clr0[0] = 1'b1; step();
    chk("clr_set_wins", 0, 0, get_err(0, 0), 1);
    req0[0] = 1'b0; step(); clr0[0] = 1'b0;
    chk("clr_alone", 0, 0, get_err(0, 0), 0);

    // Reset mid-flight
    do_reset();
    run_to(10);
    req0[0] = 1'b1; step(); req0[0] = 1'b0;
    run_to(12);
    rst = 1'b1; step(); rst = 1'b0;
    chk("mid_ack", 0, 0, get_ack(0, 0), 0);
    chk("mid_out", 0, 0, get_out(0, 0), 0);
    chk("mid_acc", 0, 0, get_acc(0, 0), 0);
    chk("mid_idle", 0, 0, get_idle(0), 1);
    req0[0] = 1'b1; step(); req0[0] = 1'b0;
    chk("mid_out_14", 0, 0, get_out(0, 0), 1);
    run_to(14);
    chk("mid_noack_14", 0, 0, get_ack(0, 0), 0);
    run_to(17);
    chk("mid_ack_17", 0, 0, get_ack(0, 0), 1);
    run_to(19);

    // Saturation on the 2-bit counter instance
    do_reset();
    run_to(2);
    req2[0] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("sat_acc", 2, 0, get_acc(2, 0), sat_exp[i]);
    end
    req2[0] = 1'b0;
    run_to(14);
    chk("sat_hold", 2, 0, get_acc(2, 0), 3);

    // Random traffic, checked cycle by cycle against the expectation queue
    do_reset();
    for (int i = 0; i < 120; i++) begin
      req0 = 2'($urandom_range(0, 3));
      req1 = 2'($urandom_range(0, 3));
      req2 = 2'($urandom_range(0, 3));
      clr0 = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      clr1 = 2'($urandom_range(0, 3));
      step();
    end
    req0 = '0; req1 = '0; req2 = '0; clr0 = '0; clr1 = '0;
    for (int i = 0; i < LAT + 2; i++) step();
    for (int d = 0; d < 3; d++) chk("drain_idle", d, 0, get_idle(d), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
